// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer: req/ack fetch from imem, valid/ready delivery to decode.
// Optional fetch timeout with a sticky error state is compiled in by defining FETCH_TIMEOUT_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_err,
  output logic [1:0]  fsm_state
);

  // Handshakes: imem_req/imem_addr are held until the cycle imem_ack=1 (rdata valid that cycle);
  // instr_valid/instr are held until the cycle instr_ready=1, which retires the word and loads npc.
`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2, S_ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        unused_npc_lsb;

  assign unused_npc_lsb = ^npc[1:0];

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit;

  // Final REQ cycle without an ack; an ack in that same cycle still completes the fetch.
  assign tmo_hit = (state_q == S_REQ) && !imem_ack && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 8'h00;
    end else if (state_q == S_REQ && !imem_ack) begin
      tmo_cnt <= tmo_cnt + 8'h01;
    end else begin
      tmo_cnt <= 8'h00;
    end
  end

  assign fetch_err = (state_q == S_ERR);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          state_d = S_HOLD;
`ifdef FETCH_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = S_ERR;
`endif
        end
      end
      S_HOLD: begin
        if (instr_ready) state_d = S_REQ;
      end
`ifdef FETCH_TIMEOUT_EN
      S_ERR: state_d = S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == S_REQ && imem_ack) instr_q <= imem_rdata;
      // npc is only meaningful at the retire handshake; low bits dropped to keep pc word-aligned.
      if (state_q == S_HOLD && instr_ready) pc_q <= {npc[31:2], 2'b00};
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == S_REQ);
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch: reset, sequential stream, backpressure/branch, memory wait,
// stray ack, misaligned npc, async reset mid-request, and (with FETCH_TIMEOUT_EN) timeout.
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;
  logic [1:0]  fsm_state;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  pc_fetch #(.RESET_PC(32'h0000_3000), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .npc         (npc),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err),
    .fsm_state   (fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_req(input string tag, input logic [31:0] exp_addr);
    check({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] exp_instr);
    check({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    check({tag, "_instr"}, instr, exp_instr);
  endtask

  logic [31:0] addr_tbl [4];
  logic [31:0] word_tbl [4];

  initial begin
    addr_tbl[0] = 32'h0000_3000; word_tbl[0] = 32'h2008_0005;
    addr_tbl[1] = 32'h0000_3004; word_tbl[1] = 32'h2009_0007;
    addr_tbl[2] = 32'h0000_3008; word_tbl[2] = 32'h0109_5020;
    addr_tbl[3] = 32'h0000_300C; word_tbl[3] = 32'hAC0A_0000;

    rst = 1'b1; npc = 32'h0; imem_ack = 1'b1; imem_rdata = word_tbl[0]; instr_ready = 1'b1;
    #2;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_addr", imem_addr, 32'h0000_3000);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_err", {31'h0, fetch_err}, 32'h0);
    check("rst_state", {30'h0, fsm_state}, {30'h0, ST_IDLE});
    tick();
    rst = 1'b0;

    // Reset then zero-wait fetch
    tick();
    check_req("first_req", 32'h0000_3000);
    tick();
    check_hold("first_hold", 32'h2008_0005);
    check("first_pc", pc, 32'h0000_3000);

    // Sequential stream: one instruction per 2 cycles
    for (int i = 1; i < 4; i++) begin
      npc = addr_tbl[i];
      imem_rdata = word_tbl[i];
      tick();
      check_req("seq_req", addr_tbl[i]);
      check("seq_pc", pc, addr_tbl[i]);
      tick();
      check_hold("seq_hold", word_tbl[i]);
    end

    // Decode backpressure then branch
    instr_ready = 1'b0;
    npc = 32'hDEAD_BEEF;
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_hold("stall", 32'hAC0A_0000);
      check("stall_pc", pc, 32'h0000_300C);
    end
    npc = 32'h0000_3040;
    instr_ready = 1'b1;
    tick();
    check_req("branch", 32'h0000_3040);

    // Memory wait: ack withheld for 5 REQ cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      check_req("wait", 32'h0000_3040);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h8C08_0010;
    instr_ready = 1'b0;
    tick();
    check_hold("wait_done", 32'h8C08_0010);

    // Stray ack during HOLD must not capture rdata
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    check_hold("stray", 32'h8C08_0010);
    imem_ack = 1'b0;

    // Misaligned npc
    npc = 32'h0000_3013;
    instr_ready = 1'b1;
    tick();
    check("misalign_pc", pc, 32'h0000_3010);
    check_req("misalign", 32'h0000_3010);

    // Walk to REQ at 0x3008, then async reset between edges
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    check_hold("pre_rst", 32'h1234_5678);
    npc = 32'h0000_3008;
    imem_ack = 1'b0;
    tick();
    check_req("pre_rst", 32'h0000_3008);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", {31'h0, imem_req}, 32'h0);
    check("arst_pc", pc, 32'h0000_3000);
    check("arst_instr", instr, 32'h0);
    check("arst_valid", {31'h0, instr_valid}, 32'h0);
    rst = 1'b0;
    tick();
    check_req("restart", 32'h0000_3000);

`ifdef FETCH_TIMEOUT_EN
    // Ack arrives in the 16th REQ cycle: fetch completes normally
    for (int i = 0; i < 15; i++) tick();
    check_req("tmo_late", 32'h0000_3000);
    imem_ack = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    tick();
    check_hold("tmo_late_hold", 32'h0BAD_F00D);
    check("tmo_late_err", {31'h0, fetch_err}, 32'h0);

    // Never ack: error after 16 REQ cycles, sticky until reset
    imem_ack = 1'b0;
    npc = 32'h0000_3004;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check_req("tmo_last", 32'h0000_3004);
    check("tmo_last_err", {31'h0, fetch_err}, 32'h0);
    tick();
    check("tmo_err", {31'h0, fetch_err}, 32'h1);
    check("tmo_req", {31'h0, imem_req}, 32'h0);
    check("tmo_valid", {31'h0, instr_valid}, 32'h0);
    imem_ack = 1'b1;
    npc = 32'h0000_3100;
    for (int i = 0; i < 3; i++) tick();
    check("tmo_sticky", {31'h0, fetch_err}, 32'h1);
    check("tmo_sticky_req", {31'h0, imem_req}, 32'h0);
    check("tmo_pc", pc, 32'h0000_3004);
    rst = 1'b1;
    #1;
    check("tmo_clear", {31'h0, fetch_err}, 32'h0);
    rst = 1'b0;
`else
    check("no_tmo_err", {31'h0, fetch_err}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
